pipe_stage_skid_reg: RTL and testbench

- Parametrised elastic pipeline stage register for the five-stage datapath.
- Generalised successor to the fixed-field stage latches (IF/ID through MEM/WB). Generic control and data buses, valid/ready handshake, 2-entry skid buffer, synchronous flush, bubble insertion, stall-cycle counter.
- Instantiated between any two pipeline stages. Lets a downstream stall propagate upstream one cycle late without losing data.

---
 rtl/pipe_stage_skid_reg.sv | 130 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - elastic pipeline stage register with 2-entry skid buffer
// Main entry drives the outputs; the skid entry absorbs the one-cycle-late downstream stall.
module pipe_stage_skid_reg #(
   parameter int                 CTRL_W      = 4,
   parameter int                 DATA_W      = 69,
   parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
   parameter int                 CNT_W       = 16
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Flush,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [CTRL_W-1:0] In_Ctrl,
   input  logic [DATA_W-1:0] In_Data,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [CTRL_W-1:0] Out_Ctrl,
   output logic [DATA_W-1:0] Out_Data,
   output logic [CNT_W-1:0]  StallCount
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              ready_q;
   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CNT_W-1:0]  cnt_q;

   logic accept;
   logic issue;

   assign accept = In_Valid & ready_q;
   assign issue  = valid_q & Out_Ready;

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      ctrl_d      = ctrl_q;
      data_d      = data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_ONE;
               valid_d = 1'b1;
               ctrl_d  = In_Ctrl;
               data_d  = In_Data;
            end
         end
         ST_ONE: begin
            if (accept && issue) begin
               ctrl_d = In_Ctrl;
               data_d = In_Data;
            end else if (accept) begin
               state_d     = ST_FULL;
               skid_ctrl_d = In_Ctrl;
               skid_data_d = In_Data;
            end else if (issue) begin
               // Leaving the last entry: bubble the control bundle, keep data stable.
               state_d = ST_EMPTY;
               valid_d = 1'b0;
               ctrl_d  = BUBBLE_CTRL;
            end
         end
         ST_FULL: begin
            if (issue) begin
               state_d = ST_ONE;
               ctrl_d  = skid_ctrl_q;
               data_d  = skid_data_q;
            end
         end
         default: begin
            state_d = ST_EMPTY;
            valid_d = 1'b0;
            ctrl_d  = BUBBLE_CTRL;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q     <= ST_EMPTY;
         ready_q     <= 1'b0;
         valid_q     <= 1'b0;
         ctrl_q      <= BUBBLE_CTRL;
         data_q      <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else if (Flush) begin
         state_q <= ST_EMPTY;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         ctrl_q  <= BUBBLE_CTRL;
      end else begin
         state_q     <= state_d;
         ready_q     <= (state_d != ST_FULL);
         valid_q     <= valid_d;
         ctrl_q      <= ctrl_d;
         data_q      <= data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   // Stall counting looks at the pre-flush output state, so a flushed stall still counts.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         cnt_q <= '0;
      end else if (valid_q && !Out_Ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign In_Ready   = ready_q;
   assign Out_Valid  = valid_q;
   assign Out_Ctrl   = ctrl_q;
   assign Out_Data   = data_q;
   assign StallCount = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - directed self-checking bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

   localparam logic [3:0] BUB = 4'h5;

   logic        Clk = 1'b0;
   logic        Reset_n, Flush, In_Valid, Out_Ready;
   logic [3:0]  In_Ctrl;
   logic [68:0] In_Data;
   logic        In_Ready, Out_Valid;
   logic [3:0]  Out_Ctrl;
   logic [68:0] Out_Data;
   logic [15:0] StallCount;

   logic        s_flush, s_valid, s_ready, s_in_ready, s_out_valid;
   logic [3:0]  s_ctrl, s_out_ctrl;
   logic [7:0]  s_data, s_out_data;
   logic [2:0]  s_count;

   int tests  = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   pipe_stage_skid_reg #(.CTRL_W(4), .DATA_W(69), .BUBBLE_CTRL(BUB), .CNT_W(16)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .In_Ctrl(In_Ctrl), .In_Data(In_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data), .StallCount(StallCount)
   );

   pipe_stage_skid_reg #(.CTRL_W(4), .DATA_W(8), .BUBBLE_CTRL(4'h0), .CNT_W(3)) dut_sat (
      .Clk(Clk), .Reset_n(Reset_n), .Flush(s_flush), .In_Valid(s_valid), .In_Ready(s_in_ready),
      .In_Ctrl(s_ctrl), .In_Data(s_data), .Out_Valid(s_out_valid), .Out_Ready(s_ready),
      .Out_Ctrl(s_out_ctrl), .Out_Data(s_out_data), .StallCount(s_count)
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic push(input logic [3:0] c, input logic [68:0] d);
      In_Valid = 1'b1;
      In_Ctrl  = c;
      In_Data  = d;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; Flush = 1'b0; Out_Ready = 1'b1;
      push(4'h3, 69'h1F);
      step();
      tests++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", In_Ready); end
      tests++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", Out_Valid); end
      tests++; if (Out_Ctrl !== BUB) begin errors++; $display("FAIL rst_out_ctrl got %h want %h", Out_Ctrl, BUB); end
      tests++; if (Out_Data !== 69'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", Out_Data); end
      tests++; if (StallCount !== 16'd0) begin errors++; $display("FAIL rst_stall got %0d want 0", StallCount); end
      step();
      tests++; if (In_Ready !== 1'b0 || Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_hold got rdy=%b vld=%b want 0 0", In_Ready, Out_Valid); end
      Reset_n = 1'b1; In_Valid = 1'b0;
      step();
      tests++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", In_Ready); end
      tests++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid got %b want 0", Out_Valid); end
      tests++; if (s_count !== 3'd0) begin errors++; $display("FAIL rst_sat_count got %0d want 0", s_count); end
   endtask

   task automatic test_streaming();
      Out_Ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push(4'(i + 8), 69'(i));
         tests++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, In_Ready); end
         step();
         tests++; if (Out_Valid !== 1'b1 || Out_Data !== 69'(i) || Out_Ctrl !== 4'(i + 8))
            begin errors++; $display("FAIL stream_out[%0d] got vld=%b data=%0d ctrl=%h want 1 %0d %h", i, Out_Valid, Out_Data, Out_Ctrl, i, 4'(i + 8)); end
      end
      In_Valid = 1'b0;
      step();
      tests++; if (Out_Valid !== 1'b0 || Out_Ctrl !== BUB || Out_Data !== 69'd8)
         begin errors++; $display("FAIL stream_drain got vld=%b ctrl=%h data=%0d want 0 %h 8", Out_Valid, Out_Ctrl, Out_Data, BUB); end
      tests++; if (StallCount !== 16'd0) begin errors++; $display("FAIL stream_stall got %0d want 0", StallCount); end
   endtask

   task automatic test_backpressure();
      Out_Ready = 1'b1;
      push(4'h1, 69'h1_0000_0000_0000_00A1);
      step();
      Out_Ready = 1'b0;
      push(4'h2, 69'h0B2);
      step();
      tests++; if (Out_Data !== 69'h1_0000_0000_0000_00A1 || In_Ready !== 1'b0)
         begin errors++; $display("FAIL bp_full got data=%h rdy=%b want A 0", Out_Data, In_Ready); end
      push(4'h3, 69'h0C3);
      step();
      step();
      tests++; if (Out_Data !== 69'h1_0000_0000_0000_00A1 || Out_Valid !== 1'b1 || In_Ready !== 1'b0)
         begin errors++; $display("FAIL bp_hold got data=%h vld=%b rdy=%b want A 1 0", Out_Data, Out_Valid, In_Ready); end
      tests++; if (StallCount !== 16'd3) begin errors++; $display("FAIL bp_stall got %0d want 3", StallCount); end
      Out_Ready = 1'b1;
      step();
      tests++; if (Out_Data !== 69'h0B2 || Out_Ctrl !== 4'h2 || In_Ready !== 1'b1)
         begin errors++; $display("FAIL bp_issue_b got data=%h ctrl=%h rdy=%b want B2 2 1", Out_Data, Out_Ctrl, In_Ready); end
      step();
      tests++; if (Out_Data !== 69'h0C3 || Out_Valid !== 1'b1) begin errors++; $display("FAIL bp_issue_c got data=%h vld=%b want C3 1", Out_Data, Out_Valid); end
      In_Valid = 1'b0;
      step();
      tests++; if (Out_Valid !== 1'b0 || StallCount !== 16'd3)
         begin errors++; $display("FAIL bp_end got vld=%b stall=%0d want 0 3", Out_Valid, StallCount); end
   endtask

   task automatic test_flush();
      Out_Ready = 1'b0;
      push(4'h4, 69'h0E4);
      step();
      push(4'h6, 69'h0F6);
      step();
      push(4'h7, 69'h0A7);
      Flush = 1'b1;
      step();
      Flush = 1'b0; In_Valid = 1'b0;
      tests++; if (Out_Valid !== 1'b0 || Out_Ctrl !== BUB || In_Ready !== 1'b1)
         begin errors++; $display("FAIL flush_out got vld=%b ctrl=%h rdy=%b want 0 %h 1", Out_Valid, Out_Ctrl, In_Ready, BUB); end
      tests++; if (StallCount !== 16'd5 || Out_Data !== 69'h0E4)
         begin errors++; $display("FAIL flush_keep got stall=%0d data=%h want 5 E4", StallCount, Out_Data); end
      Out_Ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL flush_leak[%0d] got vld=%b data=%h want 0", i, Out_Valid, Out_Data); end
      end
   endtask

   task automatic test_flush_accept();
      Out_Ready = 1'b0;
      push(4'h8, 69'h0B8);
      step();
      push(4'hD, 69'h0DD);
      Flush = 1'b1;
      step();
      Flush = 1'b0; In_Valid = 1'b0;
      tests++; if (Out_Valid !== 1'b0 || In_Ready !== 1'b1 || StallCount !== 16'd6)
         begin errors++; $display("FAIL flacc_state got vld=%b rdy=%b stall=%0d want 0 1 6", Out_Valid, In_Ready, StallCount); end
      Out_Ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL flacc_leak[%0d] got vld=%b data=%h want 0", i, Out_Valid, Out_Data); end
      end
   endtask

   task automatic test_saturation();
      s_ready = 1'b0; s_valid = 1'b1; s_ctrl = 4'h9; s_data = 8'h5A;
      step();
      s_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         tests++; if (s_count !== 3'((k > 7) ? 7 : k))
            begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", k, s_count, (k > 7) ? 7 : k); end
      end
      tests++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h5A)
         begin errors++; $display("FAIL sat_hold got vld=%b data=%h want 1 5A", s_out_valid, s_out_data); end
   endtask

   task automatic test_reset_mid();
      Out_Ready = 1'b0;
      push(4'hE, 69'h0CE);
      step();
      push(4'hF, 69'h0DF);
      step();
      Reset_n = 1'b0;
      step();
      tests++; if (Out_Valid !== 1'b0 || Out_Ctrl !== BUB || Out_Data !== 69'h0 || In_Ready !== 1'b0)
         begin errors++; $display("FAIL mid_rst got vld=%b ctrl=%h data=%h rdy=%b want 0 %h 0 0", Out_Valid, Out_Ctrl, Out_Data, In_Ready, BUB); end
      tests++; if (StallCount !== 16'd0 || s_count !== 3'd0)
         begin errors++; $display("FAIL mid_rst_count got %0d/%0d want 0/0", StallCount, s_count); end
      Reset_n = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b1;
      step();
      step();
      tests++; if (Out_Valid !== 1'b0 || In_Ready !== 1'b1)
         begin errors++; $display("FAIL mid_rst_after got vld=%b rdy=%b want 0 1", Out_Valid, In_Ready); end
   endtask

   initial begin
      s_flush = 1'b0; s_valid = 1'b0; s_ready = 1'b1; s_ctrl = 4'h0; s_data = 8'h0;
      In_Valid = 1'b0; In_Ctrl = 4'h0; In_Data = '0; Flush = 1'b0; Out_Ready = 1'b1; Reset_n = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_flush_accept();
      test_saturation();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
